// File: rtl/uart_brg_mc.sv
// Multi-channel fractional baud-rate generator: per-channel I.F prescale, oversample tick,
// divided bit pulse and RX phase resync. Define UART_BRG_CFG_ERR_EN to build the cfg_err flags.
module uart_brg_mc #(
    parameter int unsigned CH     = 2,
    parameter int unsigned PRE_W  = 16,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned OVS    = 16
) (
    input  logic                clk,
    input  logic                i_rst,
    input  logic [CH-1:0]       i_en,
    input  logic [CH*PRE_W-1:0] i_prescale,
    input  logic [CH-1:0]       i_resync,
    output logic [CH-1:0]       o_tick,
    output logic [CH-1:0]       o_bit_pulse,
    output logic [CH-1:0]       o_cfg_err
);

    localparam int unsigned IW = PRE_W - FRAC_W;
    localparam int unsigned OW = $clog2(OVS);
    localparam logic [IW-1:0] I_ONE = IW'(1);
    localparam logic [OW-1:0] OVS_ONE = OW'(1);
    localparam logic [OW-1:0] OVS_LAST = OW'(OVS - 1);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [IW-1:0]     w_i;
        logic [IW-1:0]     w_i_eff;
        logic [FRAC_W-1:0] w_f;
        logic [FRAC_W:0]   w_frac_sum;

        logic [IW-1:0]     r_int_cnt;
        logic [FRAC_W-1:0] r_frac_acc;
        logic              r_ovf;
        logic [OW-1:0]     r_ovs_cnt;
        logic              r_tick;
        logic              r_bit_pulse;

        assign w_i        = i_prescale[c*PRE_W+FRAC_W +: IW];
        assign w_f        = i_prescale[c*PRE_W +: FRAC_W];
        // An integer part of zero would stall the counter, so it runs as a 1-cycle period.
        assign w_i_eff    = (w_i == '0) ? I_ONE : w_i;
        assign w_frac_sum = {1'b0, r_frac_acc} + {1'b0, w_f};

        always_ff @(posedge clk) begin
            r_tick      <= 1'b0;
            r_bit_pulse <= 1'b0;
            if (i_rst || !i_en[c]) begin
                r_int_cnt  <= '0;
                r_frac_acc <= '0;
                r_ovf      <= 1'b0;
                r_ovs_cnt  <= '0;
            end else if (i_resync[c]) begin
                // Half-period load puts the next tick at mid-bit.
                r_int_cnt  <= w_i_eff >> 1;
                r_frac_acc <= '0;
                r_ovf      <= 1'b0;
                r_ovs_cnt  <= '0;
            end else if (r_ovf) begin
                r_ovf <= 1'b0;
            end else if (r_int_cnt != '0) begin
                r_int_cnt <= r_int_cnt - I_ONE;
            end else begin
                r_int_cnt               <= w_i_eff - I_ONE;
                {r_ovf, r_frac_acc}     <= w_frac_sum;
                r_tick                  <= 1'b1;
                r_bit_pulse             <= (r_ovs_cnt == OVS_LAST);
                r_ovs_cnt               <= (r_ovs_cnt == OVS_LAST) ? '0 : r_ovs_cnt + OVS_ONE;
            end
        end

        assign o_tick[c]      = r_tick;
        assign o_bit_pulse[c] = r_bit_pulse;

`ifdef UART_BRG_CFG_ERR_EN
        logic r_cfg_err;

        always_ff @(posedge clk) begin
            if (i_rst || !i_en[c]) begin
                r_cfg_err <= 1'b0;
            end else if (w_i == '0) begin
                r_cfg_err <= 1'b1;
            end
        end

        assign o_cfg_err[c] = r_cfg_err;
`else
        assign o_cfg_err[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_uart_brg_mc.sv
// Self-checking bench for uart_brg_mc: vector table of prescale runs plus resync, prescale-change
// and reset sequences; expected tick cycles come from the closed form t0 + n*I + floor(n*F/2^FRAC_W).
module tb_uart_brg_mc;

    localparam int CH     = 2;
    localparam int PRE_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    typedef struct packed {
        int cyc;
        bit bp;
    } exp_t;

    typedef struct {
        int          ch;
        logic [15:0] pre;
        int          win;
        int          exp_ticks;
        int          exp_bps;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       en;
    logic [CH*PRE_W-1:0] prescale;
    logic [CH-1:0]       resync;
    logic [CH-1:0]       tick;
    logic [CH-1:0]       bit_pulse;
    logic [CH-1:0]       cfg_err;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [CH-1:0] watch = '0;
    int            tick_cnt [CH];
    int            bp_cnt [CH];
    exp_t          sbq [CH][$];
    vec_t          vecs [6];

    uart_brg_mc #(
        .CH     (CH),
        .PRE_W  (PRE_W),
        .FRAC_W (FRAC_W),
        .OVS    (OVS)
    ) dut (
        .clk         (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_prescale  (prescale),
        .i_resync    (resync),
        .o_tick      (tick),
        .o_bit_pulse (bit_pulse),
        .o_cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic push_run(input int c, input int t0, input int ieff, input int f,
                            input int n0, input int t_end);
        int   n = 0;
        int   t = t0;
        exp_t e;
        while (t <= t_end) begin
            e.cyc = t;
            e.bp  = ((n0 + n + 1) % OVS) == 0;
            sbq[c].push_back(e);
            n++;
            t = t0 + n * ieff + (n * f) / (1 << FRAC_W);
        end
    endtask

    task automatic clear_sb();
        for (int c = 0; c < CH; c++) begin
            sbq[c].delete();
            tick_cnt[c] = 0;
            bp_cnt[c]   = 0;
        end
    endtask

    // Scoreboard: every watched tick must match the head of its channel queue.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < CH; c++) begin
            if (watch[c]) begin
                while (sbq[c].size() > 0 && sbq[c][0].cyc < cyc) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL missed_tick ch%0d: got no tick, required tick at cyc %0d",
                             c, sbq[c][0].cyc);
                    void'(sbq[c].pop_front());
                end
                if (tick[c]) begin
                    n_checks++;
                    if (sbq[c].size() == 0 || sbq[c][0].cyc != cyc) begin
                        n_errors++;
                        $display("FAIL unexpected_tick ch%0d: got tick at cyc %0d, required none",
                                 c, cyc);
                    end else begin
                        e = sbq[c].pop_front();
                        tick_cnt[c]++;
                        if (bit_pulse[c]) bp_cnt[c]++;
                        if (bit_pulse[c] !== e.bp) begin
                            n_errors++;
                            $display("FAIL bit_pulse ch%0d @cyc %0d: got %0b, required %0b",
                                     c, cyc, bit_pulse[c], e.bp);
                        end
                    end
                end else if (bit_pulse[c]) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL bit_pulse_no_tick ch%0d @cyc %0d: got 1, required 0", c, cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int            k;
        int            ch;
        int            ieff;
        int            f;
        logic [CH-1:0] cfg_req;

        vecs[0] = '{ch: 0, pre: 16'h0050, win: 160, exp_ticks: 32,  exp_bps: 2};
        vecs[1] = '{ch: 0, pre: 16'h0018, win: 200, exp_ticks: 134, exp_bps: 8};
        vecs[2] = '{ch: 0, pre: 16'h0030, win: 100, exp_ticks: 34,  exp_bps: 2};
        vecs[3] = '{ch: 1, pre: 16'h0008, win: 50,  exp_ticks: 34,  exp_bps: 2};
        vecs[4] = '{ch: 0, pre: 16'h0000, win: 40,  exp_ticks: 40,  exp_bps: 2};
        vecs[5] = '{ch: 1, pre: 16'h0025, win: 100, exp_ticks: 44,  exp_bps: 2};

        // Reset held 3 cycles with both channels enabled.
        rst      = 1'b1;
        en       = 2'b11;
        resync   = 2'b00;
        prescale = {16'h0008, 16'h0050};
        repeat (3) begin
            @(negedge clk);
            chk("rst_tick", tick, 2'b00);
            chk("rst_bit_pulse", bit_pulse, 2'b00);
            chk("rst_cfg_err", cfg_err, 2'b00);
        end
        #1 rst = 1'b0;
        #2;
        chk("post_rst_tick", tick, 2'b00);
        chk("post_rst_cfg_err", cfg_err, 2'b00);
        @(negedge clk);
        chk("first_tick", tick, 2'b11);
        chk("first_bit_pulse", bit_pulse, 2'b00);
`ifdef UART_BRG_CFG_ERR_EN
        chk("first_cfg_err", cfg_err, 2'b10);
`else
        chk("first_cfg_err", cfg_err, 2'b00);
`endif
        @(negedge clk);
        chk("second_tick", tick, 2'b10);
        #1 en = 2'b00;
        @(negedge clk);
        chk("dis_tick", tick, 2'b00);
        chk("dis_cfg_err", cfg_err, 2'b00);

        // Vector table: enable one channel from idle and watch a fixed window.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #2;
            k  = cyc;
            ch = vecs[i].ch;
            clear_sb();
            ieff = (vecs[i].pre[15:4] == 12'd0) ? 1 : int'(vecs[i].pre[15:4]);
            f    = int'(vecs[i].pre[3:0]);
            prescale                 = '0;
            prescale[ch*PRE_W +: 16] = vecs[i].pre;
            en                       = '0;
            en[ch]                   = 1'b1;
            watch                    = en;
            push_run(ch, k + 1, ieff, f, 0, k + vecs[i].win);
            repeat (vecs[i].win) @(posedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("vec%0d_ticks", i), tick_cnt[ch], vecs[i].exp_ticks);
            chk($sformatf("vec%0d_bit_pulses", i), bp_cnt[ch], vecs[i].exp_bps);
            chk($sformatf("vec%0d_pending", i), sbq[ch].size(), 0);
            cfg_req = '0;
`ifdef UART_BRG_CFG_ERR_EN
            if (vecs[i].pre[15:4] == 12'd0) cfg_req[ch] = 1'b1;
`endif
            chk($sformatf("vec%0d_cfg_err", i), cfg_err, cfg_req);
            en    = '0;
            watch = '0;
            @(negedge clk);
            chk($sformatf("vec%0d_dis_tick", i), tick, 2'b00);
            chk($sformatf("vec%0d_dis_cfg_err", i), cfg_err, 2'b00);
        end

        // Resync on ch1 three cycles after a tick, then again coincident with an expiry.
        @(posedge clk);
        #2;
        k = cyc;
        clear_sb();
        prescale = {16'h00A0, 16'h0050};
        en       = 2'b11;
        watch    = 2'b11;
        push_run(0, k + 1, 5, 0, 0, k + 340);
        push_run(1, k + 1, 10, 0, 0, k + 11);
        repeat (13) @(posedge clk);
        #2;
        resync = 2'b10;
        push_run(1, k + 20, 10, 0, 0, k + 170);
        @(posedge clk);
        #2;
        resync = 2'b00;
        repeat (165) @(posedge clk);
        #2;
        resync = 2'b10;
        push_run(1, k + 186, 10, 0, 0, k + 340);
        @(posedge clk);
        #2;
        resync = 2'b00;
        repeat (160) @(posedge clk);
        @(negedge clk);
        #1;
        chk("resync_ch1_ticks", tick_cnt[1], 34);
        chk("resync_ch1_bit_pulses", bp_cnt[1], 2);
        chk("resync_ch0_ticks", tick_cnt[0], 68);
        chk("resync_ch0_bit_pulses", bp_cnt[0], 4);
        chk("resync_pending", sbq[0].size() + sbq[1].size(), 0);
        en    = '0;
        watch = '0;

        // Prescale 0x0050 -> 0x0030 mid-period on ch0.
        @(posedge clk);
        #2;
        k = cyc;
        clear_sb();
        prescale = {16'h0000, 16'h0050};
        en       = 2'b01;
        watch    = 2'b01;
        push_run(0, k + 1, 5, 0, 0, k + 11);
        push_run(0, k + 16, 3, 0, 3, k + 60);
        repeat (13) @(posedge clk);
        #2;
        prescale[15:0] = 16'h0030;
        repeat (47) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pchg_ticks", tick_cnt[0], 18);
        chk("pchg_bit_pulses", bp_cnt[0], 1);
        chk("pchg_pending", sbq[0].size(), 0);
        en    = '0;
        watch = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
